// File: rtl/alu_muldiv_seq_pkg.sv
// Shared definitions for the sequential multiply/divide unit: encodings,
// iteration/latency constants and small operand helpers.
package alu_muldiv_seq_pkg;

    localparam int unsigned DATA_W       = 32;
    localparam int unsigned ACC_W        = 2 * DATA_W;
    localparam int unsigned ADD_W        = DATA_W + 1;
    localparam int unsigned CNT_W        = 6;
    localparam int unsigned ITER_COUNT   = 32;
    localparam int unsigned LAT_NORMAL   = 34;
    localparam int unsigned LAT_DIV_ZERO = 1;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_RUN  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_e;

    // Operation request captured when start is accepted
    typedef struct packed {
        op_e               op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } req_t;

    function automatic logic is_div(input op_e op);
        return op[1];
    endfunction

    function automatic logic is_signed(input op_e op);
        return op[0];
    endfunction

    function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] x);
        return x[DATA_W-1] ? (~x + DATA_W'(1)) : x;
    endfunction

    // Edges from acceptance to the edge that raises done
    function automatic int unsigned op_latency(input op_e op, input logic [DATA_W-1:0] b);
        return (is_div(op) && (b == '0)) ? LAT_DIV_ZERO : LAT_NORMAL;
    endfunction

endpackage

// File: rtl/alu_muldiv_seq_addsub.sv
// 33-bit adder/subtractor shared by the multiply accumulate and the
// restoring-divide trial subtraction; cout is carry (add) or no-borrow (sub).
module muldiv_addsub33
    import alu_muldiv_seq_pkg::*;
(
    input  logic [ADD_W-1:0] a,
    input  logic [ADD_W-1:0] b,
    input  logic             sub,
    output logic [ADD_W-1:0] y,
    output logic             cout
);

    logic [ADD_W:0] sum;

    always_comb begin
        sum  = {1'b0, a} + {1'b0, (sub ? ~b : b)} + (ADD_W + 1)'(sub);
        y    = sum[ADD_W-1:0];
        cout = sum[ADD_W];
    end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Iterative 32x32 multiply (shift-add) and divide (restoring) unit with
// signed/unsigned variants, 34-edge latency and divide-by-zero shortcut.
module alu_muldiv_seq
    import alu_muldiv_seq_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] HI,
    output logic [DATA_W-1:0] LO,
    output logic              div_zero
);

    state_e             state;
    state_e             state_nx;
    req_t               req;
    logic [ACC_W-1:0]   acc;
    logic [DATA_W-1:0]  opnd;
    logic [CNT_W-1:0]   cnt;

    logic               busy_nx;
    logic               done_nx;
    logic               req_div;
    logic               req_sgn;
    logic               div_by_zero;
    logic [DATA_W-1:0]  a_opnd;
    logic [DATA_W-1:0]  b_opnd;

    logic [ADD_W-1:0]   add_a;
    logic [ADD_W-1:0]   add_b;
    logic [ADD_W-1:0]   add_y;
    logic               add_cout;
    logic [ACC_W-1:0]   acc_nx;

    logic [ACC_W-1:0]   prod_fix;
    logic [DATA_W-1:0]  quo_fix;
    logic [DATA_W-1:0]  rem_fix;
    logic [DATA_W-1:0]  res_hi;
    logic [DATA_W-1:0]  res_lo;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_PREP;
            S_PREP:  state_nx = div_by_zero ? S_DONE : S_RUN;
            S_RUN:   if (cnt == CNT_W'(ITER_COUNT - 1)) state_nx = S_FIX;
            S_FIX:   state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Status flags follow the state being entered so they register in step with it
    always_comb begin
        busy_nx = 1'b0;
        done_nx = 1'b0;
        busy_nx = (state_nx != S_IDLE);
        done_nx = (state_nx == S_DONE);
    end

    always_comb begin
        req_div     = is_div(req.op);
        req_sgn     = is_signed(req.op);
        div_by_zero = req_div && (req.b == '0);
        a_opnd      = req_sgn ? abs_val(req.a) : req.a;
        b_opnd      = req_sgn ? abs_val(req.b) : req.b;
    end

    // Multiply: acc = {partial product, multiplier}; divide: acc = {remainder, dividend}
    always_comb begin
        if (req_div) begin
            add_a = acc[ACC_W-2:DATA_W-1];
            add_b = {1'b0, opnd};
        end else begin
            add_a = {1'b0, acc[ACC_W-1:DATA_W]};
            add_b = acc[0] ? {1'b0, opnd} : '0;
        end
    end

    muldiv_addsub33 u_addsub (
        .a    (add_a),
        .b    (add_b),
        .sub  (req_div),
        .y    (add_y),
        .cout (add_cout)
    );

    always_comb begin
        if (req_div) begin
            acc_nx = {(add_cout ? add_y[DATA_W-1:0] : acc[ACC_W-2:DATA_W-1]),
                      acc[DATA_W-2:0], add_cout};
        end else begin
            acc_nx = {add_y, acc[DATA_W-1:1]};
        end
    end

    // Sign correction applied on the FIX->DONE edge
    always_comb begin
        prod_fix = (req_sgn && (req.a[DATA_W-1] ^ req.b[DATA_W-1]))
                   ? (~acc + ACC_W'(1)) : acc;
        quo_fix  = (req_sgn && (req.a[DATA_W-1] ^ req.b[DATA_W-1]))
                   ? (~acc[DATA_W-1:0] + DATA_W'(1)) : acc[DATA_W-1:0];
        rem_fix  = (req_sgn && req.a[DATA_W-1])
                   ? (~acc[ACC_W-1:DATA_W] + DATA_W'(1)) : acc[ACC_W-1:DATA_W];
        res_hi   = req_div ? rem_fix : prod_fix[ACC_W-1:DATA_W];
        res_lo   = req_div ? quo_fix : prod_fix[DATA_W-1:0];
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            req      <= '0;
            acc      <= '0;
            opnd     <= '0;
            cnt      <= '0;
            HI       <= '0;
            LO       <= '0;
            div_zero <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            busy <= busy_nx;
            done <= done_nx;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        req      <= '{op: op_e'(op), a: A, b: B};
                        div_zero <= 1'b0;
                    end
                end
                S_PREP: begin
                    cnt  <= '0;
                    acc  <= {DATA_W'(0), a_opnd};
                    opnd <= b_opnd;
                    if (div_by_zero) begin
                        HI       <= req.a;
                        LO       <= '1;
                        div_zero <= 1'b1;
                    end
                end
                S_RUN: begin
                    acc <= acc_nx;
                    cnt <= cnt + CNT_W'(1);
                end
                S_FIX: begin
                    HI <= res_hi;
                    LO <= res_lo;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Scoreboard bench for alu_muldiv_seq: expected results queued at issue,
// checked against HI/LO/div_zero/latency when done pulses.
module tb_alu_muldiv_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        div_zero;

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
        int          n;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc      = 0;
    int   done_cnt = 0;
    int   n_cmp    = 0;
    int   n_bad    = 0;

    alu_muldiv_seq dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .A        (A),
        .B        (B),
        .busy     (busy),
        .done     (done),
        .HI       (HI),
        .LO       (LO),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference behaviour computed with native arithmetic
    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t        r;
        logic [63:0] p;
        longint      sa;
        longint      sbv;
        sa    = longint'($signed(a));
        sbv   = longint'($signed(b));
        r.tag = "";
        r.dz  = 1'b0;
        r.lat = 34;
        r.n   = 0;
        case (o)
            2'b00: p = {32'd0, a} * {32'd0, b};
            2'b01: p = 64'(sa * sbv);
            default: begin
                if (b == 32'd0) begin
                    r.dz  = 1'b1;
                    r.lat = 1;
                    p     = {a, 32'hFFFF_FFFF};
                end else if (o == 2'b10) begin
                    p = {a % b, a / b};
                end else begin
                    p = {32'(sa % sbv), 32'(sa / sbv)};
                end
            end
        endcase
        r.hi = p[63:32];
        r.lo = p[31:0];
        return r;
    endfunction

    // Result monitor
    always @(posedge clk) begin
        #1;
        if (done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("spurious_done", 64'(sb.size()), 64'd1);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.tag, "_hi"}, 64'(HI), 64'(mon_e.hi));
                chk({mon_e.tag, "_lo"}, 64'(LO), 64'(mon_e.lo));
                chk({mon_e.tag, "_dz"}, 64'(div_zero), 64'(mon_e.dz));
                chk({mon_e.tag, "_lat"}, 64'(cyc - mon_e.n), 64'(mon_e.lat));
            end
        end
    end

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input bit hold);
        exp_t e;
        int   d0;
        e     = model(o, a, b);
        e.tag = tag;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        e.n   = cyc + 1;
        sb.push_back(e);
        d0    = done_cnt;
        @(posedge clk);
        #1;
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        for (int i = 0; i < 60 && done_cnt == d0; i++) begin
            @(negedge clk);
            if (hold) begin
                A = $urandom;
                B = $urandom;
            end else begin
                start = 1'b0;
            end
        end
        if (done_cnt == d0) chk({tag, "_timeout"}, 64'(done_cnt), 64'(d0 + 1));
        start = 1'b0;
        if (hold) begin
            repeat (6) @(negedge clk);
            chk({tag, "_one_done"}, 64'(done_cnt), 64'(d0 + 1));
        end
        @(negedge clk);
        chk({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int d0;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        reset = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        A     = 32'd0;
        B     = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi", 64'(HI), 64'd0);
        chk("rst_lo", 64'(LO), 64'd0);
        chk("rst_dz", 64'(div_zero), 64'd0);

        run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'd5, 1'b0);
        run_op("div_neg", 2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("divu_zero", 2'b10, 32'd7, 32'd0, 1'b0);
        run_op("divu_7_2", 2'b10, 32'd7, 32'd2, 1'b0);
        run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("div_zero_s", 2'b11, 32'hFFFF_FF00, 32'd0, 1'b0);
        run_op("hold", 2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        run_op("mult_mix", 2'b01, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
        run_op("div_rneg", 2'b11, 32'd100, 32'hFFFF_FFF9, 1'b0);

        for (int i = 0; i < 8; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom >> $urandom_range(0, 28));
            run_op($sformatf("rand%0d", i), ro, ra, rb, 1'b0);
        end

        // Abort mid-multiply with HI/LO/div_zero all non-zero beforehand
        run_op("pre_abort", 2'b10, 32'd9, 32'd0, 1'b0);
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        op    = 2'b00;
        A     = 32'd11;
        B     = 32'd13;
        @(posedge clk);
        repeat (10) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_hi", 64'(HI), 64'd0);
        chk("abort_lo", 64'(LO), 64'd0);
        chk("abort_dz", 64'(div_zero), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        chk("abort_no_done", 64'(done_cnt), 64'(d0));
        run_op("post_abort", 2'b00, 32'd3, 32'd5, 1'b0);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_muldiv_seq.md
ALU_MULDIV_SEQ -- requirements
Module: alu_muldiv_seq

Interface
REQ-001 Interface SHALL have one clock and synchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 start  input  1  operation request; sampled only in IDLE.
REQ-005 op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 A  input  32  multiplicand / dividend.
REQ-007 B  input  32  multiplier / divisor.
REQ-008 busy  output  1  high in every state other than IDLE.
REQ-009 done  output  1  one-cycle pulse; HI/LO valid from this cycle.
REQ-010 HI  output  32  product upper word / remainder.
REQ-011 LO  output  32  product lower word / quotient.
REQ-012 div_zero  output  1  last division had B==0; held until next accepted start.

Function
REQ-013 States SHALL be IDLE, PREP, RUN, FIX, DONE.
REQ-014 IDLE->PREP SHALL occur at edge N when start=1; A, B, op latched at edge N; later input changes ignored.
REQ-015 PREP SHALL load absolute values of operands (signed ops) or raw operands (unsigned ops), clear 6-bit iteration counter; PREP->RUN at edge N+1.
REQ-016 RUN SHALL perform exactly 32 iterations (edges N+2..N+33): multiply = shift-add radix-2; divide = restoring shift-subtract using 33-bit subtract, quotient bit = no-borrow.
REQ-017 RUN->FIX SHALL occur on the edge completing iteration 32; FIX->DONE at edge N+34, applying sign correction.
REQ-018 done SHALL be 1 only in DONE (cycle after edge N+34); DONE->IDLE unconditionally on next edge.
REQ-019 MULT: 64-bit result negated (two's complement) when A[31]^B[31]; MULTU: unsigned 64-bit product.
REQ-020 DIV: quotient negated when A[31]^B[31]; remainder takes dividend sign; DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-021 Divide with B==0: PREP->DONE at edge N+1, HI=A, LO=0xFFFFFFFF, div_zero=1; RUN skipped.
REQ-022 start while busy (PREP, RUN, FIX, DONE) SHALL be ignored, not queued.
REQ-023 HI/LO SHALL change only at the edge entering DONE; held otherwise.
REQ-024 div_zero SHALL clear at acceptance of next start.

Reset
REQ-025 reset=0 at any edge SHALL force IDLE, busy=0, done=0, HI=0, LO=0, div_zero=0, counter=0, including mid-operation.
REQ-026 Operation aborted by reset SHALL produce no done pulse; first start after reset release SHALL be accepted normally.

Structure
REQ-027 Shared package SHALL hold op encodings, state encoding, ITER_COUNT=32 and latency constants (34 normal, 1 div-by-zero).
REQ-028 One sub-module muldiv_addsub33 (33-bit combinational add/subtract with carry/borrow out) SHALL serve both multiply accumulate and divide trial-subtract.
REQ-029 Datapath SHALL use a single 64-bit shift register (HI:LO form) plus 32-bit operand register; no multiplier/divider operators.

Verification
REQ-030 MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> HI=0xFFFFFFFE LO=0x00000001, done after edge N+34.
REQ-031 MULT A=0xFFFFFFFD(-3) B=5 -> HI=0xFFFFFFFF LO=0xFFFFFFF1; DIV A=0xFFFFFFF9(-7) B=2 -> LO=0xFFFFFFFD HI=0xFFFFFFFF.
REQ-032 DIVU A=7 B=0 -> div_zero=1, HI=7, LO=0xFFFFFFFF, done after edge N+1; next DIVU 7/2 -> div_zero=0, LO=3, HI=1.
REQ-033 DIV A=0x80000000 B=0xFFFFFFFF -> LO=0x80000000 HI=0, done after edge N+34.
REQ-034 start held high throughout an operation with changing A/B -> exactly one done, result from operands at edge N.
REQ-035 reset=0 at edge N+10 of MULTU -> busy=0, HI=LO=0, no done; subsequent MULTU 3*5 -> LO=15, HI=0.
